// File: rtl/game_flow_ctrl.sv
// Game-flow controller: phase sequencing, BCD score, high score and lives,
// plus the sprite enable/blink qualifiers, all timed in frames.
module game_flow_ctrl #(
    parameter int NUM_LIVES       = 3,
    parameter int MAX_NUM_LIVES   = 10,
    parameter int SCORE_DIGITS    = 6,
    parameter int BONUS_DIGIT     = 2,
    parameter int TITLE_FRAMES    = 255,
    parameter int DEATH_FRAMES    = 60,
    parameter int RESPAWN_FRAMES  = 90,
    parameter int BLINK_LOG2      = 3,
    parameter int GAMEOVER_FRAMES = 300
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_pulse,
    input  logic                               start,
    input  logic                               collision,
    input  logic                               add_points,
    input  logic [7:0]                         points,
    output logic [2:0]                         state,
    output logic [$clog2(MAX_NUM_LIVES+1)-1:0] lives,
    output logic [SCORE_DIGITS*4-1:0]          score,
    output logic [SCORE_DIGITS*4-1:0]          high_score,
    output logic [7:0]                         title_scale,
    output logic                               ship_enable,
    output logic                               ship_visible,
    output logic                               invulnerable,
    output logic                               game_over,
    output logic                               bonus_pulse
);

    localparam int LW   = $clog2(MAX_NUM_LIVES + 1);
    localparam int SW   = SCORE_DIGITS * 4;
    localparam int UW   = (SCORE_DIGITS - BONUS_DIGIT) * 4;
    localparam int M0   = (DEATH_FRAMES > RESPAWN_FRAMES) ? DEATH_FRAMES : RESPAWN_FRAMES;
    localparam int M1   = (M0 > GAMEOVER_FRAMES) ? M0 : GAMEOVER_FRAMES;
    localparam int MAXF = (M1 > TITLE_FRAMES) ? M1 : TITLE_FRAMES;
    localparam int FW   = $clog2(MAXF + 1);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_PLAY      = 3'd1,
        S_DYING     = 3'd2,
        S_RESPAWN   = 3'd3,
        S_GAME_OVER = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [7:0]    title_q, title_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] hs_q, hs_d;
    logic [SW-1:0] sum, pts;
    logic [UW-1:0] upper_q, upper_d;
    logic          start_q;
    logic          bonus_q;
    logic          carry;
    logic [4:0]    dig;
    logic          start_rise, active, coll, bonus_inc;

    assign start_rise = start & ~start_q;
    assign active     = (state_q == S_PLAY) || (state_q == S_DYING) ||
                        (state_q == S_RESPAWN);
    assign coll       = (state_q == S_PLAY) && collision;
    // Upper score field changed since last cycle: one bonus per add.
    assign bonus_inc  = active && (score_q[SW-1 -: UW] != upper_q);

    // Single-cycle ripple BCD adder, saturating at all nines.
    always_comb begin
        pts   = {{(SW-8){1'b0}}, points};
        sum   = '0;
        carry = 1'b0;
        dig   = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            dig = {1'b0, score_q[i*4 +: 4]} + {1'b0, pts[i*4 +: 4]} + {4'd0, carry};
            carry = (dig > 5'd9);
            if (carry) dig = dig - 5'd10;
            sum[i*4 +: 4] = dig[3:0];
        end
        if (carry) sum = {SCORE_DIGITS{4'h9}};
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        hs_d         = hs_q;
        title_d      = title_q;
        upper_d      = score_q[SW-1 -: UW];
        ship_enable  = 1'b0;
        ship_visible = 1'b0;
        invulnerable = 1'b0;
        game_over    = 1'b0;

        if (add_points && active) score_d = sum;

        if (bonus_inc && coll) begin
            lives_d = lives_q;
        end else if (bonus_inc) begin
            if (lives_q != LW'(MAX_NUM_LIVES)) lives_d = lives_q + 1'b1;
        end else if (coll) begin
            lives_d = lives_q - 1'b1;
        end

        unique case (state_q)
            S_TITLE: begin
                if (frame_pulse && title_q != 8'hFF) title_d = title_q + 8'd1;
                if (start_rise && int'(title_q) >= TITLE_FRAMES) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    upper_d = '0;
                    lives_d = LW'(NUM_LIVES);
                end
            end
            S_PLAY: begin
                ship_enable  = 1'b1;
                ship_visible = 1'b1;
                if (coll) begin
                    state_d = (lives_q == LW'(1) && !bonus_inc) ? S_GAME_OVER : S_DYING;
                end
            end
            S_DYING: begin
                if (frame_pulse && frame_q == FW'(DEATH_FRAMES - 1)) state_d = S_RESPAWN;
            end
            S_RESPAWN: begin
                ship_enable  = 1'b1;
                invulnerable = 1'b1;
                ship_visible = ~frame_q[BLINK_LOG2];
                if (frame_pulse && frame_q == FW'(RESPAWN_FRAMES - 1)) state_d = S_PLAY;
            end
            S_GAME_OVER: begin
                game_over = 1'b1;
                if (start_rise || (frame_pulse && frame_q == FW'(GAMEOVER_FRAMES - 1))) begin
                    state_d = S_TITLE;
                    title_d = '0;
                end
            end
            default: state_d = S_TITLE;
        endcase

        if (state_d == S_GAME_OVER && state_q != S_GAME_OVER && score_d > hs_q) hs_d = score_d;
    end

    always_comb begin
        frame_d = frame_q;
        if (state_d != state_q) frame_d = '0;
        else if (frame_pulse)   frame_d = frame_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_TITLE;
            frame_q <= '0;
            title_q <= '0;
            lives_q <= '0;
            score_q <= '0;
            hs_q    <= '0;
            upper_q <= '0;
            start_q <= 1'b1;
            bonus_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            title_q <= title_d;
            lives_q <= lives_d;
            score_q <= score_d;
            hs_q    <= hs_d;
            upper_q <= upper_d;
            start_q <= start;
            bonus_q <= bonus_inc;
        end
    end

    assign state       = state_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign high_score  = hs_q;
    assign title_scale = title_q;
    assign bonus_pulse = bonus_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: phases, scoring, bonus lives, high
// score, saturation and mid-game reset, with hand-computed expectations.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_pulse;
    logic        start;
    logic        collision;
    logic        add_points;
    logic [7:0]  points;
    logic [2:0]  state;
    logic [3:0]  lives;
    logic [23:0] score;
    logic [23:0] high_score;
    logic [7:0]  title_scale;
    logic        ship_enable;
    logic        ship_visible;
    logic        invulnerable;
    logic        game_over;
    logic        bonus_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    game_flow_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_pulse  (frame_pulse),
        .start        (start),
        .collision    (collision),
        .add_points   (add_points),
        .points       (points),
        .state        (state),
        .lives        (lives),
        .score        (score),
        .high_score   (high_score),
        .title_scale  (title_scale),
        .ship_enable  (ship_enable),
        .ship_visible (ship_visible),
        .invulnerable (invulnerable),
        .game_over    (game_over),
        .bonus_pulse  (bonus_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_pulse = 1'b1;
            tick();
            frame_pulse = 1'b0;
            tick();
        end
    endtask

    task automatic press();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic collide();
        collision = 1'b1;
        tick();
        collision = 1'b0;
    endtask

    task automatic add(input logic [7:0] v);
        points     = v;
        add_points = 1'b1;
        tick();
        add_points = 1'b0;
        tick();
        tick();
    endtask

    task automatic die_respawn();
        collide();
        frames(60);
        frames(90);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; frame_pulse = 1'b0;
        collision = 1'b0; add_points = 1'b0; points = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_state", state, 0);
        chk("rst_lives", lives, 0);
        chk("rst_score", score, 0);
        chk("rst_hs", high_score, 0);
        chk("rst_title", title_scale, 0);
        chk("rst_ship_en", ship_enable, 0);
        chk("rst_bonus", bonus_pulse, 0);
        start = 1'b0;
        tick();

        // Game 1: title ramp, early start ignored
        frames(100);
        chk("title_100", title_scale, 100);
        press();
        chk("early_start", state, 0);
        frames(155);
        chk("title_255", title_scale, 255);
        frames(5);
        chk("title_hold", title_scale, 255);
        press();
        chk("g1_state", state, 1);
        chk("g1_lives", lives, 3);
        chk("g1_score", score, 0);

        collide();
        chk("die_state", state, 2);
        chk("die_lives", lives, 2);
        chk("die_ship_en", ship_enable, 0);
        frames(59);
        chk("dying_59", state, 2);
        frames(1);
        chk("respawn", state, 3);
        chk("resp_inv", invulnerable, 1);
        chk("resp_vis0", ship_visible, 1);
        collide();
        chk("resp_coll_st", state, 3);
        chk("resp_coll_lv", lives, 2);
        frames(8);
        chk("resp_vis8", ship_visible, 0);
        frames(8);
        chk("resp_vis16", ship_visible, 1);
        frames(73);
        chk("resp_89", state, 3);
        frames(1);
        chk("resp_done", state, 1);
        chk("play_inv", invulnerable, 0);
        chk("play_vis", ship_visible, 1);

        die_respawn();
        chk("g1_lives1", lives, 1);
        add(8'h90);
        chk("g1_score90", score, 24'h000090);
        collide();
        chk("go_state", state, 4);
        chk("go_lives", lives, 0);
        chk("go_flag", game_over, 1);
        chk("go_hs90", high_score, 24'h000090);
        press();
        chk("go_start_exit", state, 0);
        chk("go_title0", title_scale, 0);

        // Game 2: bonus life and high-score update
        frames(255);
        press();
        chk("g2_state", state, 1);
        chk("g2_score", score, 0);
        chk("g2_hs_keep", high_score, 24'h000090);
        add(8'h95);
        chk("g2_s95", score, 24'h000095);
        chk("g2_nobonus", lives, 3);
        points = 8'h10; add_points = 1'b1;
        tick();
        add_points = 1'b0;
        chk("g2_s105", score, 24'h000105);
        chk("g2_bp_early", bonus_pulse, 0);
        tick();
        chk("g2_bp", bonus_pulse, 1);
        chk("g2_lives4", lives, 4);
        tick();
        chk("g2_bp_once", bonus_pulse, 0);
        add(8'h45);
        chk("g2_s150", score, 24'h000150);
        die_respawn(); die_respawn(); die_respawn();
        chk("g2_lives1", lives, 1);
        collide();
        chk("g2_go", state, 4);
        chk("g2_hs150", high_score, 24'h000150);
        frames(299);
        chk("g2_go_299", state, 4);
        frames(1);
        chk("g2_go_300", state, 0);
        chk("g2_title0", title_scale, 0);

        // Game 3: title add dropped, bonus+collision, saturations, reset
        add(8'h50);
        chk("title_add", score, 24'h000150);
        frames(255);
        press();
        chk("g3_lives", lives, 3);
        die_respawn(); die_respawn();
        add(8'h99);
        chk("g3_s99", score, 24'h000099);
        points = 8'h01; add_points = 1'b1;
        tick();
        add_points = 1'b0; collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("bc_lives", lives, 1);
        chk("bc_state", state, 2);
        chk("bc_bp", bonus_pulse, 1);
        chk("bc_score", score, 24'h000100);
        frames(150);
        chk("g3_play", state, 1);
        for (int i = 0; i < 18; i++) add(8'h50);
        chk("g3_s1000", score, 24'h001000);
        chk("g3_lives10", lives, 10);
        add(8'h50);
        points = 8'h50; add_points = 1'b1;
        tick();
        add_points = 1'b0;
        tick();
        chk("sat_bp", bonus_pulse, 1);
        chk("sat_lives", lives, 10);
        tick();
        for (int i = 0; i < 10089; i++) begin
            points = 8'h99; add_points = 1'b1;
            tick();
            add_points = 1'b0;
            tick();
        end
        add(8'h79);
        chk("s999990", score, 24'h999990);
        add(8'h25);
        chk("s_sat", score, 24'h999999);
        collide();
        chk("g3_dying", state, 2);
        chk("g3_lives9", lives, 9);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_state", state, 0);
        chk("mr_lives", lives, 0);
        chk("mr_score", score, 0);
        chk("mr_hs", high_score, 0);
        chk("mr_title", title_scale, 0);
        chk("mr_en", ship_enable, 0);
        chk("mr_vis", ship_visible, 0);
        chk("mr_inv", invulnerable, 0);
        chk("mr_go", game_over, 0);
        chk("mr_bp", bonus_pulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
